// File: rtl/selen_lsu_pkg.sv
// Shared encodings for the SELEN load/store unit: access sizes, extender control,
// exception causes and the control FSM state type.
package selen_lsu_pkg;

   localparam logic [1:0] SZ_W = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_B = 2'b10;

   // Extender size field uses the same encoding as the access size.
   localparam logic [1:0] SX_W = SZ_W;
   localparam logic [1:0] SX_H = SZ_H;
   localparam logic [1:0] SX_B = SZ_B;

   localparam logic [1:0] EXC_NONE     = 2'b00;
   localparam logic [1:0] EXC_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_BUS      = 2'b10;
   localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   function automatic logic [2:0] sx_encode(input logic sgn, input logic [1:0] size);
      return {sgn, size};
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Execute-side request, data-memory bus and load-result signals of the LSU.
// master = the LSU itself, slave = the surrounding pipeline and memory.
interface lsu_ctrl_if;

   logic        ex_valid;
   logic        ex_load;
   logic        ex_store;
   logic [1:0]  ex_size;
   logic        ex_unsigned;
   logic [31:0] ex_addr;
   logic [31:0] ex_wdata;

   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic        dmem_err;
   logic [31:0] dmem_rdata;

   logic        lsu_stall;
   logic        lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic [2:0]  lsu_sx_ctrl;
   logic        lsu_exc;
   logic [1:0]  lsu_exc_code;

   modport master (
      input  ex_valid, ex_load, ex_store, ex_size, ex_unsigned, ex_addr, ex_wdata,
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_ack, dmem_err, dmem_rdata,
      output lsu_stall, lsu_rvalid, lsu_rdata, lsu_sx_ctrl, lsu_exc, lsu_exc_code
   );

   modport slave (
      output ex_valid, ex_load, ex_store, ex_size, ex_unsigned, ex_addr, ex_wdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_ack, dmem_err, dmem_rdata,
      input  lsu_stall, lsu_rvalid, lsu_rdata, lsu_sx_ctrl, lsu_exc, lsu_exc_code
   );

endinterface

// File: rtl/lsu_align.sv
// Lane steering for the LSU: alignment check, byte enables, store-data replication
// and right-justified, zero-padded extraction of the returned read word.
module lsu_align
   import selen_lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  rd_size_i,
   input  logic [1:0]  rd_off_i,
   input  logic [31:0] rdata_i,
   output logic        misaligned_o,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [31:0] rd_shift;

   always_comb begin
      misaligned_o = 1'b0;
      be_o         = 4'b0000;
      wdata_o      = 32'h0;
      case (size_i)
         SZ_W: begin
            misaligned_o = (addr_lo_i != 2'b00);
            be_o         = 4'b1111;
            wdata_o      = wdata_i;
         end
         SZ_H: begin
            misaligned_o = addr_lo_i[0];
            be_o         = 4'b0011 << addr_lo_i;
            wdata_o      = {2{wdata_i[15:0]}};
         end
         SZ_B: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         default: misaligned_o = 1'b1;
      endcase
   end

   assign rd_shift = rdata_i >> {rd_off_i, 3'b000};

   always_comb begin
      rdata_o = rd_shift;
      case (rd_size_i)
         SZ_H:    rdata_o = {16'h0, rd_shift[15:0]};
         SZ_B:    rdata_o = {24'h0, rd_shift[7:0]};
         default: rdata_o = rd_shift;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// SELEN load/store control: one memory operation at a time, alignment check,
// dmem request/ack handshake with an ack watchdog, and load-result return.
//
//   state   | meaning
//   IDLE    | waiting for an operation; misaligned ops raise an exception here
//   REQ     | dmem_req held with stable bus outputs until ack or watchdog expiry
//   DONE    | one-cycle result: rvalid for loads or exception pulse
module lsu_ctrl
   import selen_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   lsu_ctrl_if.master  bus
);

   // Last REQ cycle before expiry: the counter would reach all-ones on the next step.
   localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   lsu_state_e           state_q, state_d;
   logic [TIMEOUT_W-1:0] wd_q, wd_d;
   logic                 req_q, we_q, rvalid_q, exc_q, sgn_q;
   logic [31:0]          addr_q, wdata_q, rdata_q;
   logic [3:0]           be_q;
   logic [1:0]           size_q, off_q, exc_code_q;

   logic                 op_valid, misaligned, accept, ack_take, tmo;
   logic [3:0]           be_n;
   logic [31:0]          wdata_n, rdata_ext;

   lsu_align u_align (
      .size_i       (bus.ex_size),
      .addr_lo_i    (bus.ex_addr[1:0]),
      .wdata_i      (bus.ex_wdata),
      .rd_size_i    (size_q),
      .rd_off_i     (off_q),
      .rdata_i      (bus.dmem_rdata),
      .misaligned_o (misaligned),
      .be_o         (be_n),
      .wdata_o      (wdata_n),
      .rdata_o      (rdata_ext)
   );

   assign op_valid = bus.ex_valid & (bus.ex_load | bus.ex_store);
   assign accept   = (state_q == ST_IDLE) & op_valid & ~misaligned;
   assign ack_take = (state_q == ST_REQ) & bus.dmem_ack;
   assign tmo      = (state_q == ST_REQ) & ~bus.dmem_ack & (wd_q == WD_LAST);

   always_comb begin
      state_d       = state_q;
      wd_d          = wd_q;
      bus.lsu_stall = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d       = ST_REQ;
               wd_d          = '0;
               bus.lsu_stall = 1'b1;
            end
         end
         ST_REQ: begin
            bus.lsu_stall = 1'b1;
            if (ack_take || tmo) state_d = ST_DONE;
            else                 wd_d    = wd_q + TIMEOUT_W'(1);
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wd_q       <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'h0;
         be_q       <= 4'b0000;
         wdata_q    <= 32'h0;
         size_q     <= SZ_W;
         off_q      <= 2'b00;
         sgn_q      <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= 32'h0;
         exc_q      <= 1'b0;
         exc_code_q <= EXC_NONE;
      end else begin
         state_q  <= state_d;
         wd_q     <= wd_d;
         req_q    <= (state_d == ST_REQ);
         rvalid_q <= 1'b0;
         exc_q    <= 1'b0;
         if (accept) begin
            addr_q  <= {bus.ex_addr[31:2], 2'b00};
            be_q    <= be_n;
            wdata_q <= wdata_n;
            we_q    <= bus.ex_store;
            size_q  <= bus.ex_size;
            off_q   <= bus.ex_addr[1:0];
            sgn_q   <= ~bus.ex_unsigned;
         end
         if ((state_q == ST_IDLE) && op_valid && misaligned) begin
            exc_q      <= 1'b1;
            exc_code_q <= EXC_MISALIGN;
         end
         if (ack_take) begin
            if (bus.dmem_err) begin
               exc_q      <= 1'b1;
               exc_code_q <= EXC_BUS;
            end else if (!we_q) begin
               rvalid_q <= 1'b1;
               rdata_q  <= rdata_ext;
            end
         end else if (tmo) begin
            exc_q      <= 1'b1;
            exc_code_q <= EXC_TIMEOUT;
         end
      end
   end

   assign bus.dmem_req     = req_q;
   assign bus.dmem_we      = we_q;
   assign bus.dmem_addr    = addr_q;
   assign bus.dmem_be      = be_q;
   assign bus.dmem_wdata   = wdata_q;
   assign bus.lsu_rvalid   = rvalid_q;
   assign bus.lsu_rdata    = rdata_q;
   assign bus.lsu_sx_ctrl  = sx_encode(sgn_q, size_q);
   assign bus.lsu_exc      = exc_q;
   assign bus.lsu_exc_code = exc_code_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a 4-bit watchdog (15-cycle ack timeout).
module tb_lsu_ctrl;
   import selen_lsu_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   lsu_ctrl_if bus ();

   lsu_ctrl #(.TIMEOUT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic ld, input logic st, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd);
      bus.ex_valid    = 1'b1;
      bus.ex_load     = ld;
      bus.ex_store    = st;
      bus.ex_size     = sz;
      bus.ex_unsigned = uns;
      bus.ex_addr     = addr;
      bus.ex_wdata    = wd;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus.dmem_req); end
      checks++; if (bus.dmem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", bus.dmem_we); end
      checks++; if (bus.dmem_be !== 4'b0000) begin errors++; $display("FAIL rst_be got %b want 0000", bus.dmem_be); end
      checks++; if (bus.dmem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", bus.dmem_addr); end
      checks++; if (bus.dmem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", bus.dmem_wdata); end
      checks++; if (bus.lsu_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", bus.lsu_rvalid); end
      checks++; if (bus.lsu_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", bus.lsu_rdata); end
      checks++; if (bus.lsu_sx_ctrl !== 3'b000) begin errors++; $display("FAIL rst_sx got %b want 000", bus.lsu_sx_ctrl); end
      checks++; if (bus.lsu_exc !== 1'b0) begin errors++; $display("FAIL rst_exc got %b want 0", bus.lsu_exc); end
      checks++; if (bus.lsu_exc_code !== 2'b00) begin errors++; $display("FAIL rst_code got %b want 00", bus.lsu_exc_code); end
      checks++; if (bus.lsu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", bus.lsu_stall); end
      #2 rst_n = 1'b1;
      step();
      // Stray ack in IDLE must be ignored.
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = 32'hFFFF_FFFF;
      step();
      bus.dmem_ack = 1'b0;
      @(negedge clk);
      checks++; if (bus.lsu_rvalid !== 1'b0) begin errors++; $display("FAIL idle_ack_rvalid got %b want 0", bus.lsu_rvalid); end
      checks++; if (bus.lsu_exc !== 1'b0) begin errors++; $display("FAIL idle_ack_exc got %b want 0", bus.lsu_exc); end
      checks++; if (bus.lsu_rdata !== 32'h0) begin errors++; $display("FAIL idle_ack_rdata got %h want 0", bus.lsu_rdata); end
      step();
   endtask

   task automatic test_store();
      logic [31:0] addr_v  [2] = '{32'h0000_1003, 32'h0000_0002};
      logic [31:0] wd_v    [2] = '{32'h0000_00AB, 32'h1234_5678};
      logic [1:0]  sz_v    [2] = '{SZ_B, SZ_H};
      logic [31:0] exp_a   [2] = '{32'h0000_1000, 32'h0000_0000};
      logic [3:0]  exp_be  [2] = '{4'b1000, 4'b1100};
      logic [31:0] exp_wd  [2] = '{32'hABAB_ABAB, 32'h5678_5678};
      for (int i = 0; i < 2; i++) begin
         drive_op(1'b0, 1'b1, sz_v[i], 1'b0, addr_v[i], wd_v[i]);
         @(negedge clk);
         checks++; if (bus.lsu_stall !== 1'b1) begin errors++; $display("FAIL st%0d_accept_stall got %b want 1", i, bus.lsu_stall); end
         step();
         bus.ex_valid = 1'b0;
         @(negedge clk);
         checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL st%0d_req got %b want 1", i, bus.dmem_req); end
         checks++; if (bus.dmem_we !== 1'b1) begin errors++; $display("FAIL st%0d_we got %b want 1", i, bus.dmem_we); end
         checks++; if (bus.dmem_addr !== exp_a[i]) begin errors++; $display("FAIL st%0d_addr got %h want %h", i, bus.dmem_addr, exp_a[i]); end
         checks++; if (bus.dmem_be !== exp_be[i]) begin errors++; $display("FAIL st%0d_be got %b want %b", i, bus.dmem_be, exp_be[i]); end
         checks++; if (bus.dmem_wdata !== exp_wd[i]) begin errors++; $display("FAIL st%0d_wdata got %h want %h", i, bus.dmem_wdata, exp_wd[i]); end
         bus.dmem_ack = 1'b1;
         step();
         bus.dmem_ack = 1'b0;
         @(negedge clk);
         checks++; if (bus.lsu_rvalid !== 1'b0) begin errors++; $display("FAIL st%0d_rvalid got %b want 0", i, bus.lsu_rvalid); end
         checks++; if (bus.lsu_exc !== 1'b0) begin errors++; $display("FAIL st%0d_exc got %b want 0", i, bus.lsu_exc); end
         checks++; if (bus.lsu_stall !== 1'b0) begin errors++; $display("FAIL st%0d_done_stall got %b want 0", i, bus.lsu_stall); end
         step();
      end
   endtask

   task automatic test_load_half();
      drive_op(1'b1, 1'b0, SZ_H, 1'b0, 32'h0000_2002, 32'h0);
      step();
      bus.ex_valid   = 1'b0;
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = 32'h8001_1234;
      @(negedge clk);
      checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL ldh_req got %b want 1", bus.dmem_req); end
      checks++; if (bus.dmem_be !== 4'b1100) begin errors++; $display("FAIL ldh_be got %b want 1100", bus.dmem_be); end
      checks++; if (bus.dmem_addr !== 32'h0000_2000) begin errors++; $display("FAIL ldh_addr got %h want 00002000", bus.dmem_addr); end
      checks++; if (bus.dmem_we !== 1'b0) begin errors++; $display("FAIL ldh_we got %b want 0", bus.dmem_we); end
      checks++; if (bus.lsu_rvalid !== 1'b0) begin errors++; $display("FAIL ldh_early_rvalid got %b want 0", bus.lsu_rvalid); end
      step();
      bus.dmem_ack = 1'b0;
      @(negedge clk);
      checks++; if (bus.lsu_rvalid !== 1'b1) begin errors++; $display("FAIL ldh_rvalid got %b want 1", bus.lsu_rvalid); end
      checks++; if (bus.lsu_rdata !== 32'h0000_8001) begin errors++; $display("FAIL ldh_rdata got %h want 00008001", bus.lsu_rdata); end
      checks++; if (bus.lsu_sx_ctrl !== 3'b101) begin errors++; $display("FAIL ldh_sx got %b want 101", bus.lsu_sx_ctrl); end
      step();
      @(negedge clk);
      checks++; if (bus.lsu_rvalid !== 1'b0) begin errors++; $display("FAIL ldh_rvalid_pulse got %b want 0", bus.lsu_rvalid); end
      step();
   endtask

   task automatic test_misaligned();
      logic [1:0]  sz_v   [2] = '{SZ_W, 2'b11};
      logic [31:0] addr_v [2] = '{32'h0000_3001, 32'h0000_3000};
      for (int i = 0; i < 2; i++) begin
         drive_op(1'b1, 1'b0, sz_v[i], 1'b0, addr_v[i], 32'h0);
         @(negedge clk);
         checks++; if (bus.lsu_stall !== 1'b0) begin errors++; $display("FAIL mis%0d_stall got %b want 0", i, bus.lsu_stall); end
         step();
         bus.ex_valid = 1'b0;
         @(negedge clk);
         checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL mis%0d_req got %b want 0", i, bus.dmem_req); end
         checks++; if (bus.lsu_exc !== 1'b1) begin errors++; $display("FAIL mis%0d_exc got %b want 1", i, bus.lsu_exc); end
         checks++; if (bus.lsu_exc_code !== EXC_MISALIGN) begin errors++; $display("FAIL mis%0d_code got %b want 01", i, bus.lsu_exc_code); end
         step();
         @(negedge clk);
         checks++; if (bus.lsu_exc !== 1'b0) begin errors++; $display("FAIL mis%0d_exc_pulse got %b want 0", i, bus.lsu_exc); end
         step();
      end
   endtask

   task automatic test_bus_error();
      int stalls = 0;
      drive_op(1'b1, 1'b0, SZ_B, 1'b1, 32'h0000_4001, 32'h0);
      @(negedge clk);
      if (bus.lsu_stall === 1'b1) stalls++;
      step();
      bus.ex_valid = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if (i == 5) begin
            bus.dmem_ack   = 1'b1;
            bus.dmem_err   = 1'b1;
            bus.dmem_rdata = 32'h5555_5555;
         end
         @(negedge clk);
         if (bus.lsu_stall === 1'b1) stalls++;
         if (i == 5) begin
            checks++; if (bus.dmem_be !== 4'b0010) begin errors++; $display("FAIL berr_be got %b want 0010", bus.dmem_be); end
         end
         step();
      end
      bus.dmem_ack = 1'b0;
      bus.dmem_err = 1'b0;
      @(negedge clk);
      checks++; if (stalls !== 6) begin errors++; $display("FAIL berr_stall_cycles got %0d want 6", stalls); end
      checks++; if (bus.lsu_stall !== 1'b0) begin errors++; $display("FAIL berr_done_stall got %b want 0", bus.lsu_stall); end
      checks++; if (bus.lsu_exc !== 1'b1) begin errors++; $display("FAIL berr_exc got %b want 1", bus.lsu_exc); end
      checks++; if (bus.lsu_exc_code !== EXC_BUS) begin errors++; $display("FAIL berr_code got %b want 10", bus.lsu_exc_code); end
      checks++; if (bus.lsu_rvalid !== 1'b0) begin errors++; $display("FAIL berr_rvalid got %b want 0", bus.lsu_rvalid); end
      step();
   endtask

   task automatic test_timeout();
      int reqs = 0;
      drive_op(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_5000, 32'h0);
      step();
      bus.ex_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.dmem_req !== 1'b1) break;
         reqs++;
         step();
      end
      checks++; if (reqs !== 15) begin errors++; $display("FAIL tmo_req_cycles got %0d want 15", reqs); end
      checks++; if (bus.lsu_exc !== 1'b1) begin errors++; $display("FAIL tmo_exc got %b want 1", bus.lsu_exc); end
      checks++; if (bus.lsu_exc_code !== EXC_TIMEOUT) begin errors++; $display("FAIL tmo_code got %b want 11", bus.lsu_exc_code); end
      checks++; if (bus.lsu_rvalid !== 1'b0) begin errors++; $display("FAIL tmo_rvalid got %b want 0", bus.lsu_rvalid); end
      // Present the next op during DONE; it must be accepted in the following cycle.
      drive_op(1'b1, 1'b0, SZ_B, 1'b1, 32'h0000_6002, 32'h0);
      step();
      @(negedge clk);
      checks++; if (bus.lsu_stall !== 1'b1) begin errors++; $display("FAIL tmo_next_accept got %b want 1", bus.lsu_stall); end
      step();
      bus.ex_valid   = 1'b0;
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = 32'h1122_3344;
      @(negedge clk);
      checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL tmo_next_req got %b want 1", bus.dmem_req); end
      step();
      bus.dmem_ack = 1'b0;
      @(negedge clk);
      checks++; if (bus.lsu_rvalid !== 1'b1) begin errors++; $display("FAIL ldbu_rvalid got %b want 1", bus.lsu_rvalid); end
      checks++; if (bus.lsu_rdata !== 32'h0000_0022) begin errors++; $display("FAIL ldbu_rdata got %h want 00000022", bus.lsu_rdata); end
      checks++; if (bus.lsu_sx_ctrl !== 3'b010) begin errors++; $display("FAIL ldbu_sx got %b want 010", bus.lsu_sx_ctrl); end
      step();
   endtask

   task automatic test_ack_at_expiry();
      drive_op(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_8000, 32'h0);
      step();
      bus.ex_valid = 1'b0;
      repeat (14) step();
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = 32'h1234_5678;
      @(negedge clk);
      checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL expack_req got %b want 1", bus.dmem_req); end
      step();
      bus.dmem_ack = 1'b0;
      @(negedge clk);
      checks++; if (bus.lsu_rvalid !== 1'b1) begin errors++; $display("FAIL expack_rvalid got %b want 1", bus.lsu_rvalid); end
      checks++; if (bus.lsu_exc !== 1'b0) begin errors++; $display("FAIL expack_exc got %b want 0", bus.lsu_exc); end
      checks++; if (bus.lsu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL expack_rdata got %h want 12345678", bus.lsu_rdata); end
      step();
   endtask

   task automatic test_reset_mid_req();
      drive_op(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_7000, 32'h0);
      step();
      bus.ex_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL rmid_req_before got %b want 1", bus.dmem_req); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL rmid_req_drop got %b want 0", bus.dmem_req); end
      #4 rst_n = 1'b1;
      step();
      @(negedge clk);
      checks++; if (bus.lsu_stall !== 1'b0) begin errors++; $display("FAIL rmid_idle_stall got %b want 0", bus.lsu_stall); end
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL rmid_idle_req got %b want 0", bus.dmem_req); end
      step();
      drive_op(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_7004, 32'h0);
      step();
      bus.ex_valid   = 1'b0;
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = 32'hDEAD_BEEF;
      step();
      bus.dmem_ack = 1'b0;
      @(negedge clk);
      checks++; if (bus.lsu_rvalid !== 1'b1) begin errors++; $display("FAIL rmid_rvalid got %b want 1", bus.lsu_rvalid); end
      checks++; if (bus.lsu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rmid_rdata got %h want deadbeef", bus.lsu_rdata); end
      checks++; if (bus.lsu_sx_ctrl !== 3'b100) begin errors++; $display("FAIL rmid_sx got %b want 100", bus.lsu_sx_ctrl); end
      step();
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      rst_n           = 1'b0;
      bus.ex_valid    = 1'b0;
      bus.ex_load     = 1'b0;
      bus.ex_store    = 1'b0;
      bus.ex_size     = 2'b00;
      bus.ex_unsigned = 1'b0;
      bus.ex_addr     = 32'h0;
      bus.ex_wdata    = 32'h0;
      bus.dmem_ack    = 1'b0;
      bus.dmem_err    = 1'b0;
      bus.dmem_rdata  = 32'h0;
      test_reset();
      test_store();
      test_load_half();
      test_misaligned();
      test_bus_error();
      test_timeout();
      test_ack_at_expiry();
      test_reset_mid_req();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
